// File: rtl/snn_collector_pkg.sv
// snn_collector_pkg: shared register map, STATUS layout, score width and bus FSM states.
package snn_collector_pkg;
  localparam int SCORE_W = 16;
  localparam logic [1:0] ADR_STATUS = 2'd0;
  localparam logic [1:0] ADR_DATA = 2'd1;
  localparam logic [1:0] ADR_CLASS = 2'd2;
  localparam logic [1:0] ADR_CTRL = 2'd3;
  localparam int ST_OVF = 31;
  localparam int ST_FULL = 17;
  localparam int ST_EMPTY = 16;
  localparam int CTRL_FLUSH = 31;
  typedef enum logic {WB_IDLE, WB_ACK} wb_state_t;
  function automatic logic [31:0] status_word(logic ovf, logic full, logic empty, logic [7:0] count);
    logic [31:0] s;
    s = 32'(count);
    s[ST_OVF] = ovf;
    s[ST_FULL] = full;
    s[ST_EMPTY] = empty;
    return s;
  endfunction
endpackage

// File: rtl/snn_inference_collector_if.sv
// snn_inference_collector_if: Wishbone slave bus of the SNN inference collector.
interface snn_inference_collector_if;
  logic [1:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic wb_we_i;
  logic wb_cyc_i;
  logic wb_stb_i;
  logic wb_ack_o;
  modport master(output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, input wb_dat_o, wb_ack_o);
  modport slave(input wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/snn_sync_fifo.sv
// snn_sync_fifo: power-of-two synchronous FIFO with combinational head, occupancy count and clear.
module snn_sync_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  // a push into a full FIFO is legal when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/snn_inference_collector.sv
// snn_inference_collector: decimating capture of SNN scores into a FIFO read over Wishbone.
// Define SNN_COLLECT_ARGMAX_EN to make CLASS report argmax of the head entry.
module snn_inference_collector
  import snn_collector_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int unsigned DECIM_RST = 1
) (
  input  logic wb_clk,
  input  logic wb_rst_n,
  input  logic valid_i,
  input  logic [SCORE_W-1:0] p1_i,
  input  logic [SCORE_W-1:0] p2_i,
  snn_inference_collector_if.slave wb,
  output logic irq_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  wb_state_t state;
  logic [30:0] decim;
  logic [31:0] cnt, eff_m1, rdata, class_w;
  logic [2*SCORE_W-1:0] head;
  logic [CW-1:0] count;
  logic ovf, full, empty, req, wr, ctrl_wr, flush, decim_wr, pop, capture;
  assign req = state == WB_IDLE && wb.wb_cyc_i && wb.wb_stb_i;
  assign wr = req && wb.wb_we_i;
  assign ctrl_wr = wr && wb.wb_adr_i == ADR_CTRL;
  assign flush = ctrl_wr && wb.wb_dat_i[CTRL_FLUSH];
  assign decim_wr = ctrl_wr && !wb.wb_dat_i[CTRL_FLUSH];
  assign pop = req && !wb.wb_we_i && wb.wb_adr_i == ADR_DATA && !empty;
  assign capture = valid_i && cnt == '0;
  assign eff_m1 = decim == '0 ? '0 : {1'b0, decim} - 32'd1;
  assign irq_o = ~empty;
`ifdef SNN_COLLECT_ARGMAX_EN
  assign class_w = {31'b0, !empty && ($signed(head[2*SCORE_W-1:SCORE_W]) > $signed(head[SCORE_W-1:0]))};
`else
  assign class_w = '0;
`endif
  assign rdata = wb.wb_adr_i == ADR_STATUS ? status_word(ovf, full, empty, 8'(count))
               : wb.wb_adr_i == ADR_DATA ? (empty ? '0 : head)
               : wb.wb_adr_i == ADR_CLASS ? class_w
               : {1'b0, decim};
  snn_sync_fifo #(.W(2*SCORE_W), .DEPTH(DEPTH)) u_fifo (
    .clk(wb_clk),
    .rst_n(wb_rst_n),
    .clr(flush),
    .push(capture && !flush),
    .pop(pop),
    .din({p2_i, p1_i}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) begin
      state <= WB_IDLE;
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
      decim <= 31'(DECIM_RST);
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      state <= req ? WB_ACK : WB_IDLE;
      wb.wb_ack_o <= req;
      if (req) wb.wb_dat_o <= wb.wb_we_i ? '0 : rdata;
      if (decim_wr) decim <= wb.wb_dat_i[30:0];
      cnt <= (flush || decim_wr) ? '0 : valid_i ? (cnt >= eff_m1 ? '0 : cnt + 32'd1) : cnt;
      ovf <= flush ? 1'b0 : (capture && full && !pop) ? 1'b1 : ovf;
    end
endmodule

// File: tb/tb_snn_inference_collector.sv
// tb_snn_inference_collector: directed stimulus checked every cycle against a queue-based model.
module tb_snn_inference_collector;
  localparam int DEPTH = 8;
  localparam int DECIM_RST = 1;
  logic clk = 0;
  logic rst_n = 0;
  logic valid = 0;
  logic [15:0] p1 = 0, p2 = 0;
  int tests = 0, fails = 0;
  snn_inference_collector_if bus();
  snn_inference_collector #(.DEPTH(DEPTH), .DECIM_RST(DECIM_RST)) dut (
    .wb_clk(clk), .wb_rst_n(rst_n), .valid_i(valid), .p1_i(p1), .p2_i(p2), .wb(bus), .irq_o()
  );
  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endfunction

  logic [31:0] q[$];
  bit m_ovf, m_ack, m_req, m_cap;
  int unsigned m_decim, m_eff;
  longint m_n;
  logic [31:0] m_dat, h;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_ack = 0; m_dat = 0; m_decim = DECIM_RST; m_n = 0;
    end else begin
      m_req = bus.wb_cyc_i && bus.wb_stb_i && !m_ack;
      m_eff = m_decim == 0 ? 1 : m_decim;
      m_cap = valid && (m_n % m_eff == 0);
      if (valid) m_n++;
      if (m_req) begin
        h = q.size() ? q[0] : 32'h0;
        case (bus.wb_adr_i)
          2'd0: m_dat = {m_ovf, 13'b0, q.size() == DEPTH, q.size() == 0, 8'b0, 8'(q.size())};
          2'd1: m_dat = h;
`ifdef SNN_COLLECT_ARGMAX_EN
          2'd2: m_dat = {31'b0, q.size() != 0 && $signed(h[31:16]) > $signed(h[15:0])};
`else
          2'd2: m_dat = 0;
`endif
          default: m_dat = m_decim;
        endcase
        if (bus.wb_we_i) begin
          m_dat = 0;
          if (bus.wb_adr_i == 2'd3 && bus.wb_dat_i[31]) begin
            q.delete(); m_ovf = 0; m_n = 0; m_cap = 0;
          end else if (bus.wb_adr_i == 2'd3) begin
            m_decim = bus.wb_dat_i[30:0]; m_n = 0;
          end
        end else if (bus.wb_adr_i == 2'd1 && q.size()) void'(q.pop_front());
      end
      if (m_cap) begin
        if (q.size() < DEPTH) q.push_back({p2, p1});
        else m_ovf = 1;
      end
      m_ack = m_req;
    end

  always @(negedge clk) begin
    chk("ack", {31'b0, bus.wb_ack_o}, {31'b0, m_ack});
    chk("irq", {31'b0, dut.irq_o}, {31'b0, q.size() != 0});
    if (m_ack || !rst_n) chk("dat", bus.wb_dat_o, m_dat);
  end

  task automatic xfer(input logic we, input logic [1:0] adr, input logic [31:0] wd,
                      input logic v, input logic [15:0] a, input logic [15:0] b, output logic [31:0] rd);
    int n = 0;
    @(posedge clk); #2;
    bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = we; bus.wb_adr_i = adr; bus.wb_dat_i = wd;
    valid = v; p1 = a; p2 = b;
    @(posedge clk); #2;
    valid = 0;
    do begin @(negedge clk); n++; end while (!bus.wb_ack_o && n < 4);
    if (!bus.wb_ack_o) chk("ack_timeout", 0, 1);
    rd = bus.wb_dat_o;
    @(posedge clk); #2;
    bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
  endtask
  task automatic wr(input logic [1:0] adr, input logic [31:0] d);
    logic [31:0] x;
    xfer(1, adr, d, 0, 0, 0, x);
  endtask
  task automatic rd(input logic [1:0] adr, output logic [31:0] d);
    xfer(0, adr, 0, 0, 0, 0, d);
  endtask
  task automatic pulse(input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #2;
    valid = 1; p1 = a; p2 = b;
    @(posedge clk); #2;
    valid = 0;
  endtask

  initial begin
    logic [31:0] r;
    bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0; bus.wb_adr_i = 0; bus.wb_dat_i = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    rd(0, r); chk("reset_status", r, 32'h0001_0000);
    rd(3, r); chk("reset_ctrl", r, 32'h0000_0001);
    rd(1, r); chk("empty_data", r, 32'h0);
    rd(0, r); chk("empty_no_pop", r, 32'h0001_0000);
    // decimate by 4: only pulses 0, 4 and 8 land
    wr(3, 4);
    for (int k = 0; k < 12; k++) pulse(16'(k), 16'(-k));
    rd(0, r); chk("decim4_status", r, 32'h0000_0003);
    rd(1, r); chk("decim4_e0", r, 32'h0000_0000);
    rd(1, r); chk("decim4_e1", r, 32'hFFFC_0004);
    rd(1, r); chk("decim4_e2", r, 32'hFFF8_0008);
    // overflow: 10 pulses into 8 entries
    wr(3, 1);
    for (int k = 0; k < 10; k++) pulse(16'(k + 1), 16'(16'h100 + k));
    rd(0, r); chk("ovf_status", r, 32'h8002_0008);
    for (int k = 0; k < 8; k++) begin
      rd(1, r); chk("ovf_data", r, {16'(16'h100 + k), 16'(k + 1)});
    end
    rd(0, r); chk("ovf_sticky", r, 32'h8001_0000);
    // flush after 3 captures clears ovf but keeps decim
    for (int k = 0; k < 3; k++) pulse(16'(k), 0);
    rd(0, r); chk("pre_flush", r, 32'h8000_0003);
    wr(3, 32'h8000_0000);
    rd(0, r); chk("flush_status", r, 32'h0001_0000);
    rd(3, r); chk("flush_decim", r, 32'h0000_0001);
    // pop and capture in the same cycle while full
    for (int k = 0; k < 8; k++) pulse(16'(16'h10 + k), 0);
    rd(0, r); chk("full_status", r, 32'h0002_0008);
    xfer(0, 1, 0, 1, 16'h0055, 0, r); chk("popcap_data", r, 32'h0000_0010);
    rd(0, r); chk("popcap_status", r, 32'h0002_0008);
    for (int k = 1; k < 8; k++) begin
      rd(1, r); chk("popcap_drain", r, 32'(16'h10 + k));
    end
    rd(1, r); chk("popcap_last", r, 32'h0000_0055);
    // argmax of head entry
    pulse(16'hFFFB, 16'h0003);
    pulse(16'h0007, 16'h0007);
    pulse(16'h0064, 16'hFFFE);
`ifdef SNN_COLLECT_ARGMAX_EN
    rd(2, r); chk("class0", r, 1); rd(1, r);
`else
    rd(2, r); chk("class0", r, 0); rd(1, r);
`endif
    chk("class0_data", r, 32'h0003_FFFB);
    rd(2, r); chk("class1", r, 0); rd(1, r);
    rd(2, r); chk("class2", r, 0); rd(1, r);
    chk("class2_data", r, 32'hFFFE_0064);
    rd(2, r); chk("class_empty", r, 0);
    // decim 0 behaves as 1
    wr(3, 0);
    pulse(1, 1); pulse(2, 2);
    rd(0, r); chk("decim0_status", r, 32'h0000_0002);
    rd(3, r); chk("decim0_ctrl", r, 32'h0);
    // reset mid-transfer with strobe held
    wr(3, 3); pulse(9, 9);
    @(posedge clk); #2;
    bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 0; bus.wb_adr_i = 0;
    @(posedge clk); #2;
    rst_n = 0;
    @(negedge clk);
    chk("rst_ack", {31'b0, bus.wb_ack_o}, 0);
    chk("rst_dat", bus.wb_dat_o, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk); chk("rel_noack", {31'b0, bus.wb_ack_o}, 0);
    @(negedge clk); chk("rel_ack", {31'b0, bus.wb_ack_o}, 1);
    chk("rel_status", bus.wb_dat_o, 32'h0001_0000);
    @(negedge clk); chk("ack_gap", {31'b0, bus.wb_ack_o}, 0);
    #2 bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
    rd(3, r); chk("rel_decim", r, 32'h0000_0001);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
